// File: rtl/ring_fifo.sv
// ring_fifo: parametrised power-of-two FIFO that sits between a producer and a
// consumer in the datapath.
// It supports a read and a write in the same cycle. It reports occupancy and
// status flags, has a programmable almost-full threshold, sticky error flags
// and a synchronous flush. The storage is an inferred RAM and is not reset.
//
// Parameters:
//   WORD_SIZE          data width in bits
//   LENGTH_BITS        log2 of depth; DEPTH = 1 << LENGTH_BITS
//   ALMOST_FULL_LEVEL  count at or above which almost_full asserts (1..DEPTH)
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   flush        synchronous clear of contents and error flags
//   wr_en        write request this cycle
//   wr_data      data to write
//   rd_en        read request this cycle
//   rd_ack       one-cycle pulse: rd_data holds the word popped at the previous edge
//   rd_data      last popped word; held until the next accepted read
//   count        current occupancy, 0..DEPTH
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= ALMOST_FULL_LEVEL
//   overflow     sticky: a write was dropped
//   underflow    sticky: a read was rejected
module ring_fifo #(
  parameter int WORD_SIZE         = 8,
  parameter int LENGTH_BITS       = 3,
  parameter int ALMOST_FULL_LEVEL = (1 << LENGTH_BITS) - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WORD_SIZE-1:0]   wr_data,
  input  logic                   rd_en,
  output logic                   rd_ack,
  output logic [WORD_SIZE-1:0]   rd_data,
  output logic [LENGTH_BITS:0]   count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 1 << LENGTH_BITS;
  localparam logic [LENGTH_BITS:0] FULL_COUNT = (LENGTH_BITS + 1)'(DEPTH);
  localparam logic [LENGTH_BITS:0] AF_COUNT   = (LENGTH_BITS + 1)'(ALMOST_FULL_LEVEL);

  logic [WORD_SIZE-1:0]   mem [DEPTH];
  logic [LENGTH_BITS-1:0] wr_ptr;
  logic [LENGTH_BITS-1:0] rd_ptr;
  logic                   rd_accept;
  logic                   wr_accept;
  logic [LENGTH_BITS:0]   count_next;

  // Accept decisions and next occupancy. A full FIFO still takes a write when
  // a read frees a slot at the same edge. An empty FIFO never takes a read,
  // because there is no write-to-read bypass.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    rd_accept  = 1'b0;
    wr_accept  = 1'b0;
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      rd_accept = rd_en && (count != '0);
      wr_accept = wr_en && ((count != FULL_COUNT) || rd_accept);
      if (wr_accept && !rd_accept) begin
        count_next = count + 1'b1;
      end else if (rd_accept && !wr_accept) begin
        count_next = count - 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset branch. The contents are
  // don't-care outside the occupied range, and leaving out the reset lets
  // the array map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // The flags are computed from count_next, so they change in the same
  // cycle as count.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, whatever order the statements are in.
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_ack      <= 1'b0;
      rd_data     <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        rd_ack    <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        rd_ack <= rd_accept;
        if (rd_accept) begin
          rd_data <= mem[rd_ptr];
          rd_ptr  <= rd_ptr + 1'b1;
        end else if (rd_en) begin
          underflow <= 1'b1;
        end
        if (wr_accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end else if (wr_en) begin
          overflow <= 1'b1;
        end
      end
      count       <= count_next;
      empty       <= (count_next == '0);
      full        <= (count_next == FULL_COUNT);
      almost_full <= (count_next >= AF_COUNT);
    end
  end

endmodule
